// File: rtl/spin_pkg.sv
// Shared definitions for the spinning-LED reaction game and its HEX animation stages.
package spin_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPIN  = 3'd1,
    S_JUDGE = 3'd2,
    S_PAUSE = 3'd3,
    S_WON   = 3'd4,
    S_LOST  = 3'd5
  } state_t;

  localparam int DEF_NUM_POS     = 10;
  localparam int DEF_TARGET      = 5;
  localparam int DEF_LIVES       = 3;
  localparam int DEF_WIN_HITS    = 3;
  localparam int DEF_PAUSE_TICKS = 4;

  // Bit positions of the two push-buttons in the key vector.
  localparam int NUM_KEYS  = 2;
  localparam int KEY_START = 0;
  localparam int KEY_STOP  = 1;

  // Active-low 7-segment codes {g,f,e,d,c,b,a} used by the win/lose animations.
  localparam logic [6:0] HEX_OFF = 7'b1111111;
  localparam logic [6:0] HEX_L   = 7'b1000111;
  localparam logic [6:0] HEX_O   = 7'b1000000;
  localparam logic [6:0] HEX_S   = 7'b0010010;
  localparam logic [6:0] HEX_E   = 7'b0000110;
  localparam logic [6:0] HEX_U   = 7'b1000001;
  localparam logic [6:0] HEX_N   = 7'b0101011;

endpackage

// File: rtl/key_pulse.sv
// Push-button conditioner: two-flop synchronizer followed by a registered
// falling-edge detector. A held button yields exactly one press pulse.
module key_pulse (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  // sync_pipe[0..1] is the synchronizer, sync_pipe[2] the previous synced level.
  logic [2:0] sync_pipe;

  // Shift the raw pin in and flag a high->low transition of the synced level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_pipe <= 3'b111;
      press     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], btn_n};
      press     <= sync_pipe[2] & ~sync_pipe[1];
    end
  end

endmodule

// File: rtl/spin_judge.sv
// Reaction-game controller: one-hot spinner, stop capture, hit/miss scoring,
// pause between rounds and level win/lose flags for the animation stages.
module spin_judge
  import spin_pkg::*;
#(
  parameter int NUM_POS     = DEF_NUM_POS,
  parameter int TARGET      = DEF_TARGET,
  parameter int LIVES       = DEF_LIVES,
  parameter int WIN_HITS    = DEF_WIN_HITS,
  parameter int PAUSE_TICKS = DEF_PAUSE_TICKS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          start_n,
  input  logic                          stop_n,
  output logic [NUM_POS-1:0]            led,
  output logic [$clog2(WIN_HITS+1)-1:0] hits,
  output logic [$clog2(LIVES+1)-1:0]    lives,
  output logic                          playing,
  output logic                          win,
  output logic                          lose
);

  localparam int PW = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
  localparam int HW = $clog2(WIN_HITS+1);
  localparam int LW = $clog2(LIVES+1);
  localparam int CW = $clog2(PAUSE_TICKS+1);

  state_t            state;
  logic [PW-1:0]     pos, cap, pos_inc;
  logic [HW-1:0]     hits_inc;
  logic [LW-1:0]     lives_dec;
  logic [CW-1:0]     pcnt;
  logic [NUM_KEYS-1:0] btn_n, press;
  logic              start_p, stop_p;

  assign btn_n = {stop_n, start_n};

  genvar k;
  generate
    for (k = 0; k < NUM_KEYS; k++) begin : g_key
      key_pulse u_kp (
        .clock (clock),
        .reset (reset),
        .btn_n (btn_n[k]),
        .press (press[k])
      );
    end
  endgenerate

  assign start_p = press[KEY_START];
  assign stop_p  = press[KEY_STOP];

  // Wrapping position step and non-wrapping score counters.
  assign pos_inc   = (pos == PW'(NUM_POS-1)) ? '0 : pos + 1'b1;
  assign hits_inc  = (hits == HW'(WIN_HITS)) ? hits : hits + 1'b1;
  assign lives_dec = (lives == '0) ? '0 : lives - 1'b1;

  function automatic logic [NUM_POS-1:0] onehot(input logic [PW-1:0] p);
    logic [NUM_POS-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return one << p;
  endfunction

  // Game FSM; led/playing/win/lose are updated together with the state so they stay registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      pos     <= '0;
      cap     <= '0;
      led     <= onehot('0);
      hits    <= '0;
      lives   <= LW'(LIVES);
      pcnt    <= '0;
      playing <= 1'b0;
      win     <= 1'b0;
      lose    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_WON, S_LOST: begin
          // Spinner frozen; only a start press matters, and it begins a fresh game.
          if (start_p) begin
            state   <= S_SPIN;
            pos     <= '0;
            led     <= onehot('0);
            hits    <= '0;
            lives   <= LW'(LIVES);
            playing <= 1'b1;
            win     <= 1'b0;
            lose    <= 1'b0;
          end
        end
        S_SPIN: begin
          // Stop has priority over a coincident tick: capture the un-advanced position.
          if (stop_p) begin
            cap   <= pos;
            state <= S_JUDGE;
          end else if (tick) begin
            pos <= pos_inc;
            led <= onehot(pos_inc);
          end
        end
        S_JUDGE: begin
          pcnt <= '0;
          if (cap == PW'(TARGET)) begin
            hits <= hits_inc;
            if (hits_inc == HW'(WIN_HITS)) begin
              state   <= S_WON;
              playing <= 1'b0;
              win     <= 1'b1;
            end else begin
              state <= S_PAUSE;
            end
          end else begin
            lives <= lives_dec;
            if (lives_dec == '0) begin
              state   <= S_LOST;
              playing <= 1'b0;
              lose    <= 1'b1;
            end else begin
              state <= S_PAUSE;
            end
          end
        end
        S_PAUSE: begin
          // Presses are dropped here; resume spinning from the same position.
          if (tick) begin
            if (pcnt == CW'(PAUSE_TICKS-1)) state <= S_SPIN;
            else                            pcnt  <= pcnt + 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          playing <= 1'b0;
          win     <= 1'b0;
          lose    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spin_judge.sv
// Directed bench for spin_judge: walk, hit, miss-to-lose, restart, coincidences,
// reset mid-pause, held buttons and a win.
module tb_spin_judge;

  logic       clock = 1'b0;
  logic       reset, tick, start_n, stop_n;
  logic [9:0] led;
  logic [1:0] hits, lives;
  logic       playing, win, lose;

  int n_cmp = 0;
  int n_err = 0;

  spin_judge dut (
    .clock   (clock),
    .reset   (reset),
    .tick    (tick),
    .start_n (start_n),
    .stop_n  (stop_n),
    .led     (led),
    .hits    (hits),
    .lives   (lives),
    .playing (playing),
    .win     (win),
    .lose    (lose)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    repeat (3) cyc();
  endtask

  // Pin low for one edge; returns just after the edge where the FSM consumes the pulse.
  // t raises tick exactly on that consuming edge.
  task automatic press(input logic s, input logic p, input logic t);
    start_n = ~s;
    stop_n  = ~p;
    cyc();
    start_n = 1'b1;
    stop_n  = 1'b1;
    cyc();
    cyc();
    tick = t;
    cyc();
    tick = 1'b0;
  endtask

  // Stop press followed by the judgement cycle.
  task automatic stop_judged();
    press(1'b0, 1'b1, 1'b0);
    cyc();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_led"},  32'(led), 32'h1);
    chk({tag, "_hits"}, 32'(hits), 32'd0);
    chk({tag, "_lives"}, 32'(lives), 32'd3);
    chk({tag, "_play"}, 32'(playing), 32'd0);
    chk({tag, "_win"},  32'(win), 32'd0);
    chk({tag, "_lose"}, 32'(lose), 32'd0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start_n = 1'b1; stop_n = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    check_reset_vals("rst");

    // Start and walk the full ring.
    press(1'b1, 1'b0, 1'b0);
    chk("start_play", 32'(playing), 32'd1);
    chk("start_led", 32'(led), 32'h1);
    for (int i = 1; i <= 10; i++) begin
      do_tick();
      chk($sformatf("walk%0d", i), 32'(led), 32'(1) << (i % 10));
    end

    // Hit at TARGET, pause 4 ticks (stop ignored inside), resume from 5.
    repeat (5) do_tick();
    chk("pos5", 32'(led), 32'h20);
    stop_judged();
    chk("hit_hits", 32'(hits), 32'd1);
    chk("hit_lives", 32'(lives), 32'd3);
    repeat (3) do_tick();
    chk("pause_led", 32'(led), 32'h20);
    stop_judged();
    chk("pause_stop_ign", 32'(hits), 32'd1);
    chk("pause_stop_lives", 32'(lives), 32'd3);
    do_tick();
    chk("resume_led", 32'(led), 32'h20);
    do_tick();
    chk("resume_adv", 32'(led), 32'h40);

    // Three misses at pos 2 -> LOST.
    repeat (6) do_tick();
    chk("pos2", 32'(led), 32'h4);
    stop_judged();
    chk("miss1_lives", 32'(lives), 32'd2);
    repeat (4) do_tick();
    stop_judged();
    chk("miss2_lives", 32'(lives), 32'd1);
    repeat (4) do_tick();
    press(1'b0, 1'b1, 1'b0);
    chk("judge_lose", 32'(lose), 32'd0);
    chk("judge_play", 32'(playing), 32'd1);
    cyc();
    chk("lost_lose", 32'(lose), 32'd1);
    chk("lost_lives", 32'(lives), 32'd0);
    chk("lost_play", 32'(playing), 32'd0);
    tick = 1'b1;
    repeat (100) cyc();
    tick = 1'b0;
    chk("lost_hold", 32'(lose), 32'd1);
    chk("lost_led", 32'(led), 32'h4);
    stop_judged();
    chk("lost_stop_ign", 32'(lose), 32'd1);

    // Restart from LOST.
    press(1'b1, 1'b0, 1'b0);
    chk("restart_lose", 32'(lose), 32'd0);
    chk("restart_hits", 32'(hits), 32'd0);
    chk("restart_lives", 32'(lives), 32'd3);
    chk("restart_led", 32'(led), 32'h1);
    chk("restart_play", 32'(playing), 32'd1);

    // Tick coincident with stop at pos 4: miss, no advance.
    repeat (4) do_tick();
    press(1'b0, 1'b1, 1'b1);
    cyc();
    chk("coin_lives", 32'(lives), 32'd2);
    chk("coin_led", 32'(led), 32'h10);
    repeat (4) do_tick();

    // Start and stop together in SPIN: judged as stop (miss at pos 4).
    press(1'b1, 1'b1, 1'b0);
    cyc();
    chk("ss_lives", 32'(lives), 32'd1);
    chk("ss_play", 32'(playing), 32'd1);
    repeat (4) do_tick();

    // Two hits, then reset in the middle of the pause.
    do_tick();
    stop_judged();
    repeat (4) do_tick();
    stop_judged();
    chk("hits2", 32'(hits), 32'd2);
    do_tick();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_reset_vals("midrst");
    do_tick();
    chk("idle_frozen", 32'(led), 32'h1);

    // Held start: one game start; held stop with free-running tick: one judgement only.
    start_n = 1'b0;
    repeat (50) cyc();
    start_n = 1'b1;
    cyc();
    chk("hold_start", 32'(playing), 32'd1);
    stop_n = 1'b0;
    tick = 1'b1;
    repeat (50) cyc();
    stop_n = 1'b1;
    tick = 1'b0;
    repeat (4) cyc();
    chk("hold_stop_lives", 32'(lives), 32'd2);
    chk("hold_stop_hits", 32'(hits), 32'd0);

    // Fresh game, three hits -> WON.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    repeat (5) do_tick();
    stop_judged();
    repeat (4) do_tick();
    stop_judged();
    repeat (4) do_tick();
    stop_judged();
    chk("won_win", 32'(win), 32'd1);
    chk("won_hits", 32'(hits), 32'd3);
    chk("won_play", 32'(playing), 32'd0);
    chk("won_led", 32'(led), 32'h20);
    stop_judged();
    chk("won_stop_ign", 32'(win), 32'd1);
    press(1'b1, 1'b0, 1'b0);
    chk("won_restart_win", 32'(win), 32'd0);
    chk("won_restart_hits", 32'(hits), 32'd0);
    chk("won_restart_led", 32'(led), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
